// File: rtl/cmd_dest_pkg.sv
// Shared types and default parameters for the command/destination controller.
package cmd_dest_pkg;

    localparam int unsigned DEF_ID_W      = 6;
    localparam int unsigned DEF_DEPTH     = 4;
    localparam int unsigned DEF_BUZZ_HALF = 6250;

    typedef enum logic [1:0] {
        STOP   = 2'b00,
        GO     = 2'b01,
        APPEND = 2'b10,
        RSVD   = 2'b11
    } cmd_op_t;

    typedef enum logic {
        IDLE    = 1'b0,
        TRANSIT = 1'b1
    } state_t;

endpackage

// File: rtl/cmd_dest_ctrl_if.sv
// Command, station-ID, motion and buzzer signals of the destination controller.
interface cmd_dest_ctrl_if #(
    parameter int unsigned ID_W  = 6,
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ID_W+1:0]  cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy;
    logic [ID_W+1:0]  ID;
    logic             ID_vld;
    logic             clr_ID_vld;
    logic             OK2Move;
    logic             in_transit;
    logic             go;
    logic             buzz;
    logic             buzz_n;
    logic             arrived;
    logic             cmd_err;
    logic [CNT_W-1:0] q_count;

    modport master (
        output cmd, cmd_rdy, ID, ID_vld, OK2Move,
        input  clr_cmd_rdy, clr_ID_vld, in_transit, go, buzz, buzz_n,
               arrived, cmd_err, q_count
    );

    modport slave (
        input  cmd, cmd_rdy, ID, ID_vld, OK2Move,
        output clr_cmd_rdy, clr_ID_vld, in_transit, go, buzz, buzz_n,
               arrived, cmd_err, q_count
    );
endinterface

// File: rtl/dest_fifo.sv
// Circular destination queue with flush; flush together with push loads a single entry.
module dest_fifo #(
    parameter int unsigned ID_W  = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ID_W-1:0]            din,
    output logic [ID_W-1:0]            head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic [CNT_W-1:0] cnt;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push & (flush | ~full);
    assign pop_ok  = pop & ~empty & ~flush;
    assign wr_idx  = flush ? '0 : wr_ptr;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? PTR_W'(1) : '0;
            cnt    <= push ? CNT_W'(1) : '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            if (push_ok && !pop_ok)      cnt <= cnt + CNT_W'(1);
            else if (pop_ok && !push_ok) cnt <= cnt - CNT_W'(1);
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_idx] <= din;
    end
endmodule

// File: rtl/cmd_dest_ctrl.sv
// Multi-stop command/destination controller: route FSM, arrival matching and obstacle buzzer.
module cmd_dest_ctrl
    import cmd_dest_pkg::*;
#(
    parameter int unsigned ID_W      = DEF_ID_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned BUZZ_HALF = DEF_BUZZ_HALF
) (
    input logic            clk,
    input logic            rst_n,
    cmd_dest_ctrl_if.slave bus
);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned BCNT_W = $clog2(BUZZ_HALF);

    state_t            state_q;
    state_t            state_d;
    cmd_op_t           op;
    logic [ID_W-1:0]   cmd_dst;
    logic [ID_W-1:0]   id_lo;
    logic              unused_id_hi;
    logic              flush;
    logic              push;
    logic              pop;
    logic              arrived_d;
    logic              arrived_q;
    logic              cmd_err_d;
    logic              cmd_err_q;
    logic [ID_W-1:0]   head;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              in_transit;
    logic              buzz_en;
    logic              buzz_q;
    logic [BCNT_W-1:0] buzz_cnt;

    assign op           = cmd_op_t'(bus.cmd[ID_W+1:ID_W]);
    assign cmd_dst      = bus.cmd[ID_W-1:0];
    assign id_lo        = bus.ID[ID_W-1:0];
    assign unused_id_hi = ^bus.ID[ID_W+1:ID_W];

    dest_fifo #(
        .ID_W  (ID_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (cmd_dst),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            arrived_q <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            arrived_q <= arrived_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    // Commands take priority over station IDs, so push and pop never coincide.
    always_comb begin
        state_d   = state_q;
        flush     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        arrived_d = 1'b0;
        cmd_err_d = 1'b0;
        if (bus.cmd_rdy) begin
            unique case (op)
                STOP: begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end
                GO: begin
                    flush   = 1'b1;
                    push    = 1'b1;
                    state_d = TRANSIT;
                end
                APPEND: begin
                    if (full) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        state_d = TRANSIT;
                    end
                end
                RSVD: ;
            endcase
        end else if (bus.ID_vld && state_q == TRANSIT && !empty && id_lo == head) begin
            pop       = 1'b1;
            arrived_d = 1'b1;
            if (count == CNT_W'(1)) state_d = IDLE;
        end
    end

    assign in_transit = (state_q == TRANSIT);
    assign buzz_en    = in_transit & ~bus.OK2Move;

    // Buzzer toggles every BUZZ_HALF enabled cycles and is held low otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buzz_cnt <= '0;
            buzz_q   <= 1'b0;
        end else if (!buzz_en) begin
            buzz_cnt <= '0;
            buzz_q   <= 1'b0;
        end else if (buzz_cnt == BCNT_W'(BUZZ_HALF - 1)) begin
            buzz_cnt <= '0;
            buzz_q   <= ~buzz_q;
        end else begin
            buzz_cnt <= buzz_cnt + BCNT_W'(1);
        end
    end

    assign bus.clr_cmd_rdy = bus.cmd_rdy;
    assign bus.clr_ID_vld  = bus.ID_vld;
    assign bus.in_transit  = in_transit;
    assign bus.go          = in_transit & bus.OK2Move;
    assign bus.buzz        = buzz_q;
    assign bus.buzz_n      = ~buzz_q;
    assign bus.arrived     = arrived_q;
    assign bus.cmd_err     = cmd_err_q;
    assign bus.q_count     = count;
endmodule

// File: tb/tb_cmd_dest_ctrl.sv
// Bench for cmd_dest_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_cmd_dest_ctrl;
    import cmd_dest_pkg::*;

    localparam int unsigned ID_W      = 6;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned BUZZ_HALF = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmd_dest_ctrl_if #(.ID_W(ID_W), .DEPTH(DEPTH)) bus ();

    cmd_dest_ctrl #(
        .ID_W      (ID_W),
        .DEPTH     (DEPTH),
        .BUZZ_HALF (BUZZ_HALF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: route as a plain queue, buzzer from the length of the blocked run.
    int mq[$];
    bit m_transit = 1'b0;
    int m_run     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_transit = 1'b0;
        m_run     = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_transit"}, 32'(bus.in_transit), 32'(0));
        chk({tag, "_go"},         32'(bus.go),         32'(0));
        chk({tag, "_buzz"},       32'(bus.buzz),       32'(0));
        chk({tag, "_buzz_n"},     32'(bus.buzz_n),     32'(1));
        chk({tag, "_arrived"},    32'(bus.arrived),    32'(0));
        chk({tag, "_cmd_err"},    32'(bus.cmd_err),    32'(0));
        chk({tag, "_q_count"},    32'(bus.q_count),    32'(0));
        chk({tag, "_clr_cmd"},    32'(bus.clr_cmd_rdy), 32'(0));
        chk({tag, "_clr_id"},     32'(bus.clr_ID_vld),  32'(0));
    endtask

    // One clock: drive inputs, check combinational outputs, advance model, check registered outputs.
    task automatic step(input bit rdy, input logic [1:0] op, input int dst,
                        input bit vld, input int id, input bit ok);
        bit en;
        bit arr;
        bit err;
        int bz;
        @(negedge clk);
        bus.cmd_rdy = rdy;
        bus.cmd     = {op, 6'(dst)};
        bus.ID_vld  = vld;
        bus.ID      = {2'($urandom), 6'(id)};
        bus.OK2Move = ok;
        #1;
        chk("clr_cmd_rdy", 32'(bus.clr_cmd_rdy), 32'(rdy));
        chk("clr_ID_vld",  32'(bus.clr_ID_vld),  32'(vld));
        chk("go",          32'(bus.go),          32'(m_transit && ok));
        en  = m_transit && !ok;
        arr = 1'b0;
        err = 1'b0;
        if (rdy) begin
            case (op)
                2'b00: begin mq.delete(); m_transit = 1'b0; end
                2'b01: begin mq.delete(); mq.push_back(dst % 64); m_transit = 1'b1; end
                2'b10: begin
                    if (mq.size() < int'(DEPTH)) begin
                        mq.push_back(dst % 64);
                        m_transit = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (vld && m_transit && mq.size() > 0 && (id % 64) == mq[0]) begin
            void'(mq.pop_front());
            arr = 1'b1;
            if (mq.size() == 0) m_transit = 1'b0;
        end
        m_run = en ? m_run + 1 : 0;
        bz    = (m_run / int'(BUZZ_HALF)) % 2;
        @(posedge clk);
        #1;
        chk("in_transit", 32'(bus.in_transit), 32'(m_transit));
        chk("q_count",    32'(bus.q_count),    32'(mq.size()));
        chk("arrived",    32'(bus.arrived),    32'(arr));
        chk("cmd_err",    32'(bus.cmd_err),    32'(err));
        chk("buzz",       32'(bus.buzz),       32'(bz));
        chk("buzz_n",     32'(bus.buzz_n),     32'(1 - bz));
    endtask

    task automatic idle(input bit ok);
        step(1'b0, 2'b00, 0, 1'b0, 0, ok);
    endtask

    task automatic cmd(input logic [1:0] op, input int dst);
        step(1'b1, op, dst, 1'b0, 0, 1'b1);
    endtask

    task automatic sid(input int id);
        step(1'b0, 2'b00, 0, 1'b1, id, 1'b1);
    endtask

    initial begin
        bus.cmd     = '0;
        bus.cmd_rdy = 1'b0;
        bus.ID      = '0;
        bus.ID_vld  = 1'b0;
        bus.OK2Move = 1'b1;
        model_reset();
        #1;
        check_reset("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);

        // Single stop with a non-matching then matching ID
        cmd(GO, 5);
        sid(3);
        sid(5);
        idle(1'b1);

        // Fill the queue, overflow once, then visit every stop in order
        cmd(GO, 1);
        cmd(APPEND, 2);
        cmd(APPEND, 3);
        cmd(APPEND, 4);
        cmd(APPEND, 6);
        chk("full_q_count", 32'(bus.q_count), 32'(4));
        for (int i = 1; i <= 4; i++) sid(i);
        chk("route_done", 32'(bus.in_transit), 32'(0));

        // STOP flushes; a later ID gives no arrival
        cmd(APPEND, 2);
        cmd(APPEND, 3);
        cmd(STOP, 0);
        sid(2);

        // Blocked for 40 cycles, then clear
        cmd(GO, 7);
        repeat (40) idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("unblock_go", 32'(bus.go), 32'(1));

        // Command and matching ID together: command wins
        cmd(GO, 8);
        step(1'b1, APPEND, 9, 1'b1, 8, 1'b1);
        chk("collide_q_count", 32'(bus.q_count), 32'(2));
        cmd(STOP, 0);

        // Reserved opcode is consumed without effect
        cmd(GO, 20);
        cmd(RSVD, 21);
        sid(20);

        // Reset mid-route while buzzing
        cmd(GO, 10);
        cmd(APPEND, 11);
        cmd(APPEND, 12);
        repeat (12) idle(1'b0);
        @(negedge clk);
        bus.cmd_rdy = 1'b0;
        bus.ID_vld  = 1'b0;
        rst_n       = 1'b0;
        #1;
        model_reset();
        check_reset("mid_rst");
        @(posedge clk);
        #1;
        check_reset("hold_rst");
        @(negedge clk);
        rst_n = 1'b1;
        sid(10);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            bit          rdy;
            bit          vld;
            bit          ok;
            int          sel;
            int          id;
            logic [1:0]  op;
            rdy = ($urandom_range(0, 9) < 3);
            vld = 1'($urandom_range(0, 1));
            ok  = ($urandom_range(0, 7) != 0);
            sel = int'($urandom_range(0, 9));
            op  = (sel < 3) ? GO : (sel < 8) ? APPEND : (sel == 8) ? STOP : RSVD;
            id  = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0] : int'($urandom_range(0, 63));
            step(rdy, op, int'($urandom_range(0, 63)), vld, id, ok);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/cmd_dest_ctrl.md
# cmd_dest_ctrl

Parametrised command/destination controller for the line-following robot's digital core. It consumes BLE112 commands (cmd/cmd_rdy) and barcode station IDs (ID/ID_vld), and holds a multi-stop destination queue. It drives `in_transit`/`go` to the motion controller and proximity sensor, and runs an obstacle buzzer. It is the successor of the single-destination command FSM: it adds a configurable ID width, a DEPTH-entry stop queue, an append/stop/go command set, arrival and error pulses, and a parametrised buzzer period.

## Interface
- `ID_W`, default 6: destination ID width; command and station ID words are ID_W+2 bits.
- `DEPTH`, default 4: destination queue depth (≥2).
- `BUZZ_HALF`, default 6250: buzzer half-period in clk cycles (≥2).
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd`  in  ID_W+2  command word; `[ID_W+1:ID_W]` is the opcode, `[ID_W-1:0]` is the destination.
- `cmd_rdy`  in  1  command valid, level, held until cleared.
- `clr_cmd_rdy`  out  1  knocks down cmd_rdy.
- `ID`  in  ID_W+2  station ID from the barcode unit; only `[ID_W-1:0]` is compared.
- `ID_vld`  in  1  station ID valid, level, held until cleared.
- `clr_ID_vld`  out  1  knocks down ID_vld.
- `OK2Move`  in  1  proximity sensor clear.
- `in_transit`  out  1  robot has an active route; enables the proximity sensor.
- `go`  out  1  drive enable to the motion controller.
- `buzz`, `buzz_n`  out  1 each  complementary piezo drive.
- `arrived`  out  1  one-cycle pulse when a queued stop is reached.
- `cmd_err`  out  1  one-cycle pulse when an APPEND is dropped because the queue is full.
- `q_count`  out  $clog2(DEPTH+1)  number of queued destinations.

## Operation
- Opcodes:
  - 2'b00 STOP
  - 2'b01 GO (replace the route)
  - 2'b10 APPEND
  - 2'b11 reserved; consumed with no effect.
- States: IDLE and TRANSIT. `in_transit` is 1 exactly when the registered state is TRANSIT.
- Command handling, any state: when `cmd_rdy` is 1, `clr_cmd_rdy` is 1 combinationally in the same cycle. The effect below takes hold at the next edge.
  - GO: flush the queue, push the destination (q_count=1), go to TRANSIT.
  - APPEND with q_count<DEPTH: push at the tail; from IDLE, go to TRANSIT.
  - APPEND with q_count==DEPTH: queue and state unchanged; `cmd_err` pulses.
  - STOP: flush the queue, go to IDLE.
- ID handling: when `ID_vld` is 1, `clr_ID_vld` is 1 combinationally in the same cycle, in every state.
  - In IDLE the ID is discarded.
  - In TRANSIT, if `ID[ID_W-1:0]` equals the queue head: pop and pulse `arrived`. If that was the last entry, go to IDLE; otherwise stay in TRANSIT and head for the next entry.
  - A non-matching ID is discarded.
- Simultaneous `cmd_rdy` and `ID_vld`: the command wins. The ID is still cleared, but it is discarded and causes no pop and no `arrived`.
- `go` = `in_transit & OK2Move`, combinational.
- Buzzer, with en = `in_transit & ~OK2Move`:
  - While en is 1, the counter increments. At BUZZ_HALF-1 it wraps to 0 and `buzz` toggles.
  - While en is 0, the counter and `buzz` are forced to 0.
  - `buzz_n` = ~`buzz`.
- Queue: circular buffer with head/tail pointers modulo DEPTH. Flush sets both pointers and the count to 0. A push and a pop never occur in the same cycle, because the command has priority.

## Timing
- Reset values: state IDLE, queue empty, `q_count`=0, `in_transit`=0, `go`=0, `buzz`=0, `buzz_n`=1, `arrived`=0, `cmd_err`=0, `clr_*`=0, buzzer counter=0.
- Reset asserted mid-route aborts immediately, with all outputs at their reset values.
- Latency from a cmd_rdy cycle to `in_transit`/`q_count` change: 1 clk.
- `arrived` and `cmd_err` are registered. They pulse in the cycle after the triggering event, concurrent with the state/count update.
- First `buzz` toggle: BUZZ_HALF cycles after en rises. Full buzzer period: 2·BUZZ_HALF cycles.
- The `clr_*` outputs are combinational from the `*_rdy`/`*_vld` inputs. The upstream flops drop the level at the next edge, so each clear is high for 1 cycle per item.

## Structure
- Package `cmd_dest_pkg` holds:
  - `cmd_op_t` enum (STOP, GO, APPEND, RSVD);
  - `state_t` enum (IDLE, TRANSIT);
  - the default parameter constants.
- Sub-module `dest_fifo` (parameters ID_W, DEPTH) owns the storage, pointers, count, full/empty, flush, and head output. The top level holds the FSM, the compare logic, the pulses and the buzzer.

## Test plan
Bench parameters: ID_W=6, DEPTH=4, BUZZ_HALF=8.
1. GO to 5, then ID_vld with ID=8'h03, then ID=8'h05 → clr pulses for both; `arrived` pulses once; `in_transit` drops 1 cycle after ID 5; `q_count` goes 1→0.
2. GO to 1, then APPEND 2, 3, 4, then a fifth APPEND to 6 → `q_count` reaches 4; `cmd_err` pulses once; IDs 1,2,3,4 in order give 4 `arrived` pulses and end in IDLE.
3. APPEND 2, APPEND 3, then STOP → `q_count`=0 and `in_transit`=0 one cycle after STOP; a following ID=2 is cleared with no `arrived`.
4. In TRANSIT with OK2Move=0 for 40 cycles → `go`=0 and `buzz` toggles every 8 cycles (5 toggles). When OK2Move returns to 1 → `buzz`=0 and `go`=1.
5. cmd_rdy (APPEND 9) in the same cycle as ID_vld matching the head → both clears pulse; no `arrived`; `q_count` increments by 1.
6. Reset during TRANSIT with 3 queued stops and buzzing → every output at its reset value; after reset, an ID_vld gives a clear only.
